lrf_stream_ctrl: RTL and testbench

//  Frame-level sequencer for the stall-driven similarity pipeline (xy product -> gaussian conv -> difference).

---
 rtl/lrf_pkg.sv | 25 ++
 rtl/lrf_tag_delay.sv | 45 ++++
 rtl/lrf_stream_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_lrf_stream_ctrl.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lrf_pkg.sv
// Shared definitions for the similarity-pipeline frame sequencer.
// Holds the frame FSM state type, the default geometry/latency values and
// helpers that derive beats-per-row and beats-per-frame from the geometry.
package lrf_pkg;

    localparam int LRF_PIXELS_PER_BEAT = 16;
    localparam int LRF_IMAGE_DIM       = 512;
    localparam int LRF_PIPE_LATENCY    = 104;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DONE  = 2'd3
    } lrf_state_e;

    function automatic int beats_per_row(input int pixels_per_beat, input int image_dim);
        return image_dim / pixels_per_beat;
    endfunction

    function automatic int beats_per_frame(input int pixels_per_beat, input int image_dim);
        return beats_per_row(pixels_per_beat, image_dim) * image_dim;
    endfunction

endpackage

// File: rtl/lrf_tag_delay.sv
// Valid-tag delay line that travels alongside the stalled datapath.
// A DEPTH-deep 1-bit shift register that only moves when the pipeline
// advances, so the tag at the tail always describes the beat sitting in the
// pipeline output register.
// Ports:
//   clk      clock
//   aresetn  asynchronous active-low clear of every tag
//   i_en     advance: shift one position
//   i_din    tag entering the head (1 = real beat, 0 = flush/prologue)
//   o_tail   tag at the last position
module lrf_tag_delay #(
    parameter int DEPTH = 104
) (
    input  logic clk,
    input  logic aresetn,
    input  logic i_en,
    input  logic i_din,
    output logic o_tail
);

    logic [DEPTH-1:0] r_tag;
    logic [DEPTH-1:0] w_shift;

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_shift
            if (gi == 0) begin : g_head
                assign w_shift[gi] = i_din;
            end else begin : g_body
                assign w_shift[gi] = r_tag[gi-1];
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            r_tag <= '0;
        end else if (i_en) begin
            r_tag <= w_shift;
        end
    end

    assign o_tail = r_tag[DEPTH-1];

endmodule

// File: rtl/lrf_stream_ctrl.sv
// Frame-level sequencer for the stall-driven similarity pipeline.
// Produces the single pipe_stall shared by every stage, runs the input and
// output stream handshakes, tags each beat so prologue/flush beats never reach
// the consumer, and injects flush beats after the last input so the conv line
// buffers drain a whole frame.
// Ports:
//   clk, aresetn        clock / asynchronous active-low reset
//   start               begin a frame (only honoured in IDLE)
//   s_valid/s_ready     input beat handshake, s_last = producer end-of-frame
//   m_valid/m_ready     output beat handshake, m_last = last output of frame
//   pipe_stall          1 = every pipeline stage holds
//   pipe_flush          1 = datapath input muxes select zero
//   col_idx/row_idx     position of the beat entering now
//   busy, done          frame in progress / one-cycle end-of-frame pulse
//   err_last            sticky s_last mismatch, cleared by an accepted start
module lrf_stream_ctrl
    import lrf_pkg::*;
#(
    parameter int  PIXELS_PER_BEAT = LRF_PIXELS_PER_BEAT,
    parameter int  IMAGE_DIM       = LRF_IMAGE_DIM,
    parameter int  PIPE_LATENCY    = LRF_PIPE_LATENCY,
    localparam int BPR             = beats_per_row(PIXELS_PER_BEAT, IMAGE_DIM),
    localparam int BPF             = beats_per_frame(PIXELS_PER_BEAT, IMAGE_DIM),
    localparam int CW              = $clog2(BPR),
    localparam int RW              = $clog2(IMAGE_DIM),
    localparam int NW              = $clog2(BPF + 1)
) (
    input  logic          clk,
    input  logic          aresetn,
    input  logic          start,
    input  logic          s_valid,
    input  logic          s_last,
    output logic          s_ready,
    output logic          m_valid,
    input  logic          m_ready,
    output logic          m_last,
    output logic          pipe_stall,
    output logic          pipe_flush,
    output logic [CW-1:0] col_idx,
    output logic [RW-1:0] row_idx,
    output logic          busy,
    output logic          done,
    output logic          err_last
);

    lrf_state_e    r_state;
    lrf_state_e    w_state_next;
    logic [NW-1:0] r_in_cnt;
    logic [NW-1:0] r_out_cnt;
    logic [CW-1:0] r_col;
    logic [RW-1:0] r_row;
    logic          r_tail_taken;
    logic          r_err_last;

    logic w_tail;
    logic w_mvalid;
    logic w_out_free;
    logic w_advance;
    logic w_accept;
    logic w_out_hs;
    logic w_start_acc;
    logic w_in_last;
    logic w_out_last;

    assign w_in_last  = (r_in_cnt  == NW'(BPF - 1));
    assign w_out_last = (r_out_cnt == NW'(BPF - 1));

    // The output register may be overwritten when it is empty, already
    // consumed, or being consumed this cycle.
    assign w_mvalid   = w_tail & ~r_tail_taken;
    assign w_out_free = ~w_tail | r_tail_taken | m_ready;
    assign w_advance  = ((r_state == ST_RUN) & s_valid & w_out_free)
                      | ((r_state == ST_FLUSH) & w_out_free);
    // In RUN every advance carries a new input beat, so bubbles never enter.
    assign w_accept    = (r_state == ST_RUN) & w_advance;
    assign w_out_hs    = w_mvalid & m_ready;
    assign w_start_acc = (r_state == ST_IDLE) & start;

    // Only RUN advances carry real beats; FLUSH advances shift in zero tags.
    lrf_tag_delay #(
        .DEPTH (PIPE_LATENCY)
    ) u_tag_delay (
        .clk     (clk),
        .aresetn (aresetn),
        .i_en    (w_advance),
        .i_din   (r_state == ST_RUN),
        .o_tail  (w_tail)
    );

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        s_ready      = 1'b0;
        pipe_flush   = 1'b0;
        busy         = 1'b1;
        done         = 1'b0;
        m_valid      = w_mvalid;
        m_last       = w_mvalid & w_out_last;
        pipe_stall   = ~w_advance;
        col_idx      = r_col;
        row_idx      = r_row;
        err_last     = r_err_last;
        case (r_state)
            ST_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    w_state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                s_ready = w_out_free;
                if (w_accept && w_in_last) begin
                    w_state_next = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                pipe_flush = 1'b1;
                if (w_out_hs && w_out_last) begin
                    w_state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                // start is deliberately not looked at here
                done         = 1'b1;
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            r_in_cnt   <= '0;
            r_out_cnt  <= '0;
            r_col      <= '0;
            r_row      <= '0;
            r_err_last <= 1'b0;
        end else if (w_start_acc) begin
            r_in_cnt   <= '0;
            r_out_cnt  <= '0;
            r_col      <= '0;
            r_row      <= '0;
            r_err_last <= 1'b0;
        end else begin
            if (w_accept) begin
                r_in_cnt <= r_in_cnt + NW'(1);
                if (r_col == CW'(BPR - 1)) begin
                    r_col <= '0;
                    r_row <= (r_row == RW'(IMAGE_DIM - 1)) ? '0 : r_row + RW'(1);
                end else begin
                    r_col <= r_col + CW'(1);
                end
                // The frame keeps going; the mismatch is only reported.
                if (s_last != w_in_last) begin
                    r_err_last <= 1'b1;
                end
            end
            if (w_out_hs) begin
                r_out_cnt <= r_out_cnt + NW'(1);
            end
        end
    end

    // A beat consumed while the pipe is held must not be shown again; the
    // next advance replaces the tail and clears the marker.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            r_tail_taken <= 1'b0;
        end else if (w_advance) begin
            r_tail_taken <= 1'b0;
        end else if (w_out_hs) begin
            r_tail_taken <= 1'b1;
        end
    end

endmodule

// File: tb/tb_lrf_stream_ctrl.sv
module tb_lrf_stream_ctrl;

    localparam int PPB = 16;
    localparam int DIM = 512;
    localparam int L   = 104;
    localparam int BPR = DIM / PPB;
    localparam int BPF = BPR * DIM;

    localparam int S_IDLE  = 0;
    localparam int S_RUN   = 1;
    localparam int S_FLUSH = 2;
    localparam int S_DONE  = 3;

    logic       clk = 1'b0;
    logic       aresetn, start, s_valid, s_last, m_ready;
    logic       s_ready, m_valid, m_last, pipe_stall, pipe_flush, busy, done, err_last;
    logic [4:0] col_idx;
    logic [8:0] row_idx;

    lrf_stream_ctrl dut (
        .clk        (clk),
        .aresetn    (aresetn),
        .start      (start),
        .s_valid    (s_valid),
        .s_last     (s_last),
        .s_ready    (s_ready),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_last     (m_last),
        .pipe_stall (pipe_stall),
        .pipe_flush (pipe_flush),
        .col_idx    (col_idx),
        .row_idx    (row_idx),
        .busy       (busy),
        .done       (done),
        .err_last   (err_last)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model: frame state, advances this frame, beats in/out.
    int md_st, md_k, md_in, md_out;
    bit md_taken, md_err;

    // Per-frame statistics gathered from the DUT pins.
    int cyc, acc_n, hs_n, first_acc, first_mv, last_hs, done_cyc, flush_n, mlast_n, mlast_idx;

    typedef struct {
        bit st; bit sv; bit sl; bit mr;
        bit e_sready; bit e_stall; bit e_busy; bit e_mvalid; bit e_err;
        int e_col;
    } vec_t;

    vec_t tbl [10];

    function automatic vec_t mk(bit st, bit sv, bit sl, bit mr, bit e_sready, bit e_stall,
                                bit e_busy, bit e_mvalid, bit e_err, int e_col);
        vec_t v;
        v.st = st; v.sv = sv; v.sl = sl; v.mr = mr;
        v.e_sready = e_sready; v.e_stall = e_stall; v.e_busy = e_busy;
        v.e_mvalid = e_mvalid; v.e_err = e_err; v.e_col = e_col;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d at %0t", name, act, exp, $time);
        end
    endtask

    // A real beat sits at the output once L advances have passed since it
    // entered; the frame's real beats are advances 0..BPF-1.
    function automatic bit f_mvalid();
        return (md_k >= L) && (md_k < BPF + L) && !md_taken;
    endfunction

    task automatic clear_stats();
        cyc = 0; acc_n = 0; hs_n = 0; first_acc = -1; first_mv = -1;
        last_hs = -1; done_cyc = -1; flush_n = 0; mlast_n = 0; mlast_idx = -1;
    endtask

    // One clock: compare every output with the model at the falling edge,
    // then advance the model exactly as the rising edge advances the DUT.
    task automatic step();
        bit mv, of, sr, adv, hs, acc;
        @(negedge clk);
        if (!aresetn) begin
            md_st = S_IDLE; md_k = 0; md_in = 0; md_out = 0; md_taken = 0; md_err = 0;
        end
        mv  = f_mvalid();
        of  = !mv || m_ready;
        sr  = (md_st == S_RUN) && of;
        adv = (sr && s_valid) || ((md_st == S_FLUSH) && of);
        hs  = mv && m_ready;
        acc = (md_st == S_RUN) && adv;
        chk("s_ready",    32'(s_ready),    32'(sr));
        chk("m_valid",    32'(m_valid),    32'(mv));
        chk("m_last",     32'(m_last),     32'(mv && (md_out == BPF - 1)));
        chk("pipe_stall", 32'(pipe_stall), 32'(!adv));
        chk("pipe_flush", 32'(pipe_flush), 32'(md_st == S_FLUSH));
        chk("col_idx",    32'(col_idx),    32'(md_in % BPR));
        chk("row_idx",    32'(row_idx),    32'((md_in / BPR) % DIM));
        chk("busy",       32'(busy),       32'(md_st != S_IDLE));
        chk("done",       32'(done),       32'(md_st == S_DONE));
        chk("err_last",   32'(err_last),   32'(md_err));
        if (s_valid && s_ready) begin
            if (first_acc < 0) first_acc = cyc;
            acc_n++;
        end
        if (m_valid === 1'b1 && first_mv < 0) first_mv = cyc;
        if (m_valid && m_ready) begin
            if (m_last) begin
                mlast_n++;
                mlast_idx = hs_n;
            end
            last_hs = cyc;
            hs_n++;
        end
        if (pipe_flush) flush_n++;
        if (done) done_cyc = cyc;
        cyc++;
        if (aresetn) begin
            if (hs) md_out++;
            if (adv) begin
                md_k++;
                md_taken = 0;
            end else if (hs) begin
                md_taken = 1;
            end
            case (md_st)
                S_IDLE: if (start) begin
                    md_st = S_RUN; md_in = 0; md_out = 0; md_k = 0; md_err = 0;
                end
                S_RUN: if (acc) begin
                    if (s_last != (md_in == BPF - 1)) md_err = 1;
                    md_in++;
                    if (md_in == BPF) md_st = S_FLUSH;
                end
                S_FLUSH: if (hs && md_out == BPF) md_st = S_DONE;
                default: md_st = S_IDLE;
            endcase
        end
        @(posedge clk);
        #1;
    endtask

    // mode 0: full rate; mode 1: toggled/random valid, random ready, stall
    // corner sequences and a misplaced s_last.
    task automatic run_frame(input int mode, input int bound);
        bit tog = 0;
        bit hold_done = 0;
        bit pulse_done = 0;
        int hs_before;
        for (int i = 0; i < bound && done_cyc < 0; i++) begin
            start = (md_st == S_DONE);
            if (mode == 0) begin
                s_valid = 1; m_ready = 1; s_last = (md_in == BPF - 1);
                if (md_in == 2000) start = 1;
                step();
            end else if (!hold_done && f_mvalid()) begin
                hs_before = hs_n;
                for (int h = 0; h < 20; h++) begin
                    start = 0; s_valid = 1; m_ready = 0; s_last = 0;
                    #1;
                    chk("hold_stall",  32'(pipe_stall), 32'd1);
                    chk("hold_sready", 32'(s_ready),    32'd0);
                    chk("hold_mvalid", 32'(m_valid),    32'd1);
                    step();
                end
                chk("hold_no_output", 32'(hs_n), 32'(hs_before));
                m_ready = 1;
                step();
                chk("hold_release_once", 32'(hs_n), 32'(hs_before + 1));
                hold_done = 1;
            end else if (!pulse_done && md_st == S_RUN && md_out >= 1000 && f_mvalid()) begin
                start = 0; s_valid = 0; m_ready = 1;
                hs_before = hs_n;
                step();
                #1;
                chk("starve_mvalid", 32'(m_valid),    32'd0);
                chk("starve_stall",  32'(pipe_stall), 32'd1);
                step();
                chk("starve_once", 32'(hs_n), 32'(hs_before + 1));
                pulse_done = 1;
            end else begin
                tog     = ~tog;
                s_valid = (md_in < 300) ? tog : ($urandom_range(3, 0) != 0);
                m_ready = ($urandom_range(6, 0) != 0);
                s_last  = (md_in == 100);
                step();
            end
        end
        chk("frame_done_seen", 32'(done_cyc >= 0), 32'd1);
    endtask

    initial begin
        tbl[0] = mk(0, 0, 0, 1,  0, 1, 0, 0, 0, 0);
        tbl[1] = mk(1, 1, 0, 1,  0, 1, 0, 0, 0, 0);
        tbl[2] = mk(1, 0, 0, 1,  1, 1, 1, 0, 0, 0);
        tbl[3] = mk(0, 1, 0, 1,  1, 0, 1, 0, 0, 0);
        tbl[4] = mk(0, 1, 0, 1,  1, 0, 1, 0, 0, 1);
        tbl[5] = mk(0, 0, 0, 1,  1, 1, 1, 0, 0, 2);
        tbl[6] = mk(0, 1, 1, 1,  1, 0, 1, 0, 0, 2);
        tbl[7] = mk(0, 1, 0, 1,  1, 0, 1, 0, 1, 3);
        tbl[8] = mk(0, 0, 0, 1,  1, 1, 1, 0, 1, 4);
        tbl[9] = mk(1, 1, 0, 1,  1, 0, 1, 0, 1, 4);

        aresetn = 0; start = 0; s_valid = 0; s_last = 0; m_ready = 0;
        clear_stats();
        @(posedge clk);
        #1;
        repeat (3) step();
        chk("rst_stall", 32'(pipe_stall), 32'd1);
        chk("rst_busy",  32'(busy),       32'd0);
        aresetn = 1;
        step();

        for (int v = 0; v < 10; v++) begin
            start = tbl[v].st; s_valid = tbl[v].sv; s_last = tbl[v].sl; m_ready = tbl[v].mr;
            #1;
            $display("vec %0d start=%0b s_valid=%0b s_last=%0b -> s_ready=%0b stall=%0b busy=%0b col=%0d err=%0b",
                     v, start, s_valid, s_last, s_ready, pipe_stall, busy, col_idx, err_last);
            chk("vec_s_ready",  32'(s_ready),    32'(tbl[v].e_sready));
            chk("vec_stall",    32'(pipe_stall), 32'(tbl[v].e_stall));
            chk("vec_busy",     32'(busy),       32'(tbl[v].e_busy));
            chk("vec_m_valid",  32'(m_valid),    32'(tbl[v].e_mvalid));
            chk("vec_err_last", 32'(err_last),   32'(tbl[v].e_err));
            chk("vec_col_idx",  32'(col_idx),    32'(tbl[v].e_col));
            step();
        end

        // Random traffic up to beat 5000, then reset in the middle of RUN.
        start = 0; s_last = 0;
        for (int i = 0; i < 20000 && md_in < 5000; i++) begin
            s_valid = ($urandom_range(9, 0) < 7);
            m_ready = ($urandom_range(6, 0) != 0);
            step();
        end
        chk("frame0_reached_5000", 32'(md_in), 32'd5000);
        $display("frame0 reset after %0d accepted beats", md_in);
        aresetn = 0;
        #1;
        chk("midrst_busy",    32'(busy),       32'd0);
        chk("midrst_sready",  32'(s_ready),    32'd0);
        chk("midrst_stall",   32'(pipe_stall), 32'd1);
        chk("midrst_mvalid",  32'(m_valid),    32'd0);
        chk("midrst_err",     32'(err_last),   32'd0);
        chk("midrst_col",     32'(col_idx),    32'd0);
        chk("midrst_row",     32'(row_idx),    32'd0);
        step();
        aresetn = 1;
        step();

        // Frame A: full rate.
        clear_stats();
        start = 1; s_valid = 0; m_ready = 1;
        step();
        start = 0;
        run_frame(0, 20000);
        $display("frameA in=%0d out=%0d latency=%0d flush=%0d", acc_n, hs_n, first_mv - first_acc, flush_n);
        chk("A_latency",      32'(first_mv - first_acc), 32'(L));
        chk("A_inputs",       32'(acc_n),                32'(BPF));
        chk("A_outputs",      32'(hs_n),                 32'(BPF));
        chk("A_mlast_index",  32'(mlast_idx),            32'(BPF - 1));
        chk("A_mlast_count",  32'(mlast_n),              32'd1);
        chk("A_done_delay",   32'(done_cyc - last_hs),   32'd1);
        chk("A_flush_cycles", 32'(flush_n),              32'(L));
        chk("A_err_last",     32'(err_last),             32'd0);

        // Frame B: backpressure, starvation, toggled valid, wrong s_last.
        clear_stats();
        start = 1; s_valid = 0; m_ready = 1;
        step();
        start = 0;
        run_frame(1, 60000);
        $display("frameB in=%0d out=%0d cycles=%0d err_last=%0b", acc_n, hs_n, cyc, err_last);
        chk("B_inputs",      32'(acc_n),     32'(BPF));
        chk("B_outputs",     32'(hs_n),      32'(BPF));
        chk("B_mlast_index", 32'(mlast_idx), 32'(BPF - 1));
        chk("B_err_sticky",  32'(err_last),  32'd1);

        // Frame C: an accepted start clears err_last.
        clear_stats();
        start = 1; s_valid = 1; m_ready = 1; s_last = 0;
        step();
        start = 0;
        #1;
        chk("C_err_cleared", 32'(err_last), 32'd0);
        chk("C_busy",        32'(busy),     32'd1);
        for (int i = 0; i < 200; i++) step();
        $display("frameC in=%0d out=%0d", acc_n, hs_n);
        chk("C_inputs", 32'(acc_n), 32'd200);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
